pulse_inst_scheduler: RTL and testbench
=======================================

# pulse_inst_scheduler

Host-facing controller that feeds one pulse amplitude generator's instruction list, a 32-entry ring of `{timestamp, direction}` entries.
- Accepts timestamped pulse requests over a valid/ready handshake and rejects late or out-of-order ones.
- Writes accepted entries into the ring in slot order.
- Mirrors the generator's PC by retiring entries when `glb_counter` matches, so a not-yet-executed slot is never overwritten.
- Sits between the host/sequencer and the generator's `inst_list_wr_*` port.

## Interface
- `GLB_COUNTER_WIDTH`, 24, timestamp / global counter width
- `DIRECTION_WIDTH`, 2, direction field width
- `INST_LIST_NUM_ENTRY`, 32, ring depth (power of two)
- `INST_LIST_ADDR_WIDTH`, 5, log2(ring depth)
- `INST_LIST_DATA_WIDTH`, 26, GLB_COUNTER_WIDTH+DIRECTION_WIDTH
- `LEAD_MIN`, 3, minimum required `in_timestamp - glb_counter` at acceptance (≥3)
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  soft clear; re-enters INIT
- `glb_counter`  in  24  global time
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request ready
- `in_timestamp`  in  24  pulse start time
- `in_direction`  in  2  pulse direction
- `inst_list_wr_en`  out  1  ring write enable
- `inst_list_wr_addr`  out  5  ring write address
- `inst_list_wr_data`  out  26  `{timestamp, direction}`; direction in the LSBs
- `init_done`  out  1  ring initialized, RUN state
- `occupancy`  out  6  outstanding (written, unretired) entries
- `drop_pulse`  out  1  one-cycle pulse when a request is rejected
- `drop_count`  out  8  saturating rejected-request count

## Operation
- FSM has two states.
- **INIT**
  - Entered on `rst` or `flush`.
  - Writes slot k with `{PARK_TS, 2'b00}` on cycle k, for k = 0..NUM_ENTRY-1.
  - Clears `wr_ptr`, `rd_ptr`, `occupancy` and `have_last`; leaves `drop_count` unchanged on `flush`.
  - Moves to RUN after slot NUM_ENTRY-1 is written.
- **RUN**
  - `in_ready = (occupancy != NUM_ENTRY)`.
  - On a handshake, the request is checked:
    - late: `in_timestamp < glb_counter + LEAD_MIN` (unsigned, no wrap handling);
    - out of order: `have_last && in_timestamp <= last_ts`.
  - A late or out-of-order request is consumed, `drop_pulse` asserts, `drop_count` increments (saturating at 255), and nothing is written.
  - Otherwise the request is accepted:
    - `shadow[wr_ptr]` ← timestamp;
    - `last_ts` ← timestamp, `have_last` ← 1;
    - a ring write is issued;
    - `wr_ptr` increments (wraps).
- **Retire:** when `occupancy != 0 && glb_counter == shadow[rd_ptr]`, `rd_ptr` increments (wraps). This matches the generator's PC advance.
- **Simultaneous accept and retire:** `occupancy` is unchanged. Otherwise it increments on accept and decrements on retire.
- **Full:** `in_ready = 0`. A retire in the same cycle does not raise ready until the next cycle.
- `PARK_TS` is the all-ones value; the system never lets `glb_counter` reach it.

## Timing
- **Reset values:** `in_ready` 0, `inst_list_wr_en` 0, `inst_list_wr_addr` 0, `inst_list_wr_data` 0, `init_done` 0, `occupancy` 0, `drop_pulse` 0, `drop_count` 0.
- **INIT:**
  - First INIT write is the cycle after `rst` deasserts.
  - INIT lasts NUM_ENTRY cycles.
  - `init_done` and `in_ready` rise on the first RUN cycle.
- **Write latency:** handshake at cycle t → `inst_list_wr_en = 1` at t+1, with `addr = wr_ptr(t)` and the `{ts, dir}` data. The generator sees the new entry at t+2. This is why `LEAD_MIN ≥ 3`.
- **Drop latency:** `drop_pulse` asserts at t+1, one cycle wide.
- **`occupancy`:** registered; updates at t+1.
- **`flush`/`rst` mid-RUN:** any pending write is abandoned and INIT restarts the next cycle. `rst` has priority over `flush`.

## Structure
- Shared pulse-circuit package holds:
  - `PARK_TS`;
  - width constants (GLB_COUNTER, DIRECTION, INST_LIST_ADDR/DATA);
  - the FSM state enum `{INIT, RUN}`.
- Sub-module `pulse_ts_shadow`:
  - NUM_ENTRY×GLB_COUNTER_WIDTH register array;
  - synchronous write, asynchronous read at `rd_ptr`;
  - no reset on the data.

## Test plan
- **Reset and init:** `rst` held 2 cycles, then released → 32 writes, addr 0..31, data `26'h3FFFFFC`; `init_done` = 1 at cycle 33; `occupancy` = 0.
- **Accept and retire:** with `glb_counter` = 100, send ts 110 dir 2 → write addr 0 data `{110, 2}` one cycle later; `occupancy` = 1; when `glb_counter` = 110, `occupancy` returns to 0.
- **Late and out-of-order drops:**
  - `glb_counter` = 100, send ts 102 → dropped, `drop_pulse` asserts, `drop_count` = 1, no write;
  - send ts 200, then ts 150 → second is dropped, `drop_count` = 2.
- **Full backpressure:** 32 increasing requests with no retire → `occupancy` = 32, `in_ready` = 0; retire once → ready reasserts; next write goes to addr 0 (wrap).
- **Simultaneous accept and retire** at `occupancy` = 5 → `occupancy` stays 5; `wr_ptr` and `rd_ptr` both advance.
- **Flush mid-run** with `occupancy` = 7 → INIT rewrites all 32 slots with PARK; `occupancy` = 0; `drop_count` preserved; first new request writes addr 0.

Source files
------------

// File: rtl/pulse_inst_scheduler_pkg.sv
// ------------------------------------------------------------------
// pulse_inst_scheduler_pkg: shared widths, park value and FSM states
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pulse_inst_scheduler_pkg;

  localparam int GLB_COUNTER_W       = 24;
  localparam int DIRECTION_W         = 2;
  localparam int INST_LIST_ENTRIES   = 32;
  localparam int INST_LIST_ADDR_W    = 5;
  localparam int INST_LIST_DATA_W    = GLB_COUNTER_W + DIRECTION_W;

  // Parked slots hold a time the global counter is never allowed to reach.
  localparam logic [GLB_COUNTER_W-1:0] PARK_TS = '1;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/pulse_ts_shadow.sv
// ------------------------------------------------------------------
// pulse_ts_shadow: timestamp copy of the ring, async read at rd_ptr
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pulse_ts_shadow
  import pulse_inst_scheduler_pkg::*;
#(
  parameter int NUM_ENTRY  = INST_LIST_ENTRIES,
  parameter int ADDR_WIDTH = INST_LIST_ADDR_W,
  parameter int DATA_WIDTH = GLB_COUNTER_W
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRY];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/pulse_inst_scheduler.sv
// ------------------------------------------------------------------
// pulse_inst_scheduler: checks timestamped requests, writes the ring
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pulse_inst_scheduler
  import pulse_inst_scheduler_pkg::*;
#(
  parameter int GLB_COUNTER_WIDTH    = GLB_COUNTER_W,
  parameter int DIRECTION_WIDTH      = DIRECTION_W,
  parameter int INST_LIST_NUM_ENTRY  = INST_LIST_ENTRIES,
  parameter int INST_LIST_ADDR_WIDTH = INST_LIST_ADDR_W,
  parameter int INST_LIST_DATA_WIDTH = INST_LIST_DATA_W,
  parameter int LEAD_MIN             = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [GLB_COUNTER_WIDTH-1:0]    glb_counter,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [GLB_COUNTER_WIDTH-1:0]    in_timestamp,
  input  logic [DIRECTION_WIDTH-1:0]      in_direction,
  output logic                            inst_list_wr_en,
  output logic [INST_LIST_ADDR_WIDTH-1:0] inst_list_wr_addr,
  output logic [INST_LIST_DATA_WIDTH-1:0] inst_list_wr_data,
  output logic                            init_done,
  output logic [INST_LIST_ADDR_WIDTH:0]   occupancy,
  output logic                            drop_pulse,
  output logic [7:0]                      drop_count
);

  localparam int AW = INST_LIST_ADDR_WIDTH;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(INST_LIST_NUM_ENTRY);
  localparam logic [GLB_COUNTER_WIDTH:0] LEAD = (GLB_COUNTER_WIDTH+1)'(LEAD_MIN);

  sched_state_e                     state_q, state_d;
  logic [AW:0]                      init_idx_q, init_idx_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [AW:0]                      occ_q, occ_d;
  logic                             have_last_q, have_last_d;
  logic [GLB_COUNTER_WIDTH-1:0]     last_ts_q, last_ts_d;
  logic [7:0]                       drop_cnt_q, drop_cnt_d;
  logic                             drop_pulse_q, drop_pulse_d;
  logic                             wr_en_q, wr_en_d;
  logic [AW-1:0]                    wr_addr_q, wr_addr_d;
  logic [INST_LIST_DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic                             ready;
  logic                             fire;
  logic                             late;
  logic                             out_of_order;
  logic                             accept;
  logic                             retire;
  logic                             shadow_we;
  logic [GLB_COUNTER_WIDTH-1:0]     shadow_rdata;

  pulse_ts_shadow #(
    .NUM_ENTRY  (INST_LIST_NUM_ENTRY),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (GLB_COUNTER_WIDTH)
  ) u_shadow (
    .clk     (clk),
    .we_i    (shadow_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_timestamp),
    .raddr_i (rd_ptr_q),
    .rdata_o (shadow_rdata)
  );

  assign ready        = (state_q == RUN) && (occ_q != OCC_FULL);
  assign fire         = in_valid && ready;
  assign late         = {1'b0, in_timestamp} < ({1'b0, glb_counter} + LEAD);
  assign out_of_order = have_last_q && (in_timestamp <= last_ts_q);
  assign accept       = fire && !late && !out_of_order;
  // Mirrors the generator PC: the head entry retires on the cycle its time arrives.
  assign retire       = (state_q == RUN) && (occ_q != '0) && (glb_counter == shadow_rdata);

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    have_last_d  = have_last_q;
    last_ts_d    = last_ts_q;
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    shadow_we    = 1'b0;

    case (state_q)
      INIT: begin
        if (init_idx_q == OCC_FULL) begin
          state_d = RUN;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = init_idx_q[AW-1:0];
          wr_data_d  = {PARK_TS, {DIRECTION_WIDTH{1'b0}}};
          init_idx_d = init_idx_q + (AW+1)'(1);
        end
      end
      RUN: begin
        if (fire && !accept) begin
          drop_pulse_d = 1'b1;
          drop_cnt_d   = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
        end
        if (accept) begin
          shadow_we   = 1'b1;
          wr_en_d     = 1'b1;
          wr_addr_d   = wr_ptr_q;
          wr_data_d   = {in_timestamp, in_direction};
          wr_ptr_d    = wr_ptr_q + AW'(1);
          last_ts_d   = in_timestamp;
          have_last_d = 1'b1;
        end
        if (retire) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({accept, retire})
          2'b10:   occ_d = occ_q + (AW+1)'(1);
          2'b01:   occ_d = occ_q - (AW+1)'(1);
          default: occ_d = occ_q;
        endcase
      end
      default: state_d = INIT;
    endcase

    // Soft clear abandons whatever this cycle would have done, except the drop history.
    if (flush) begin
      state_d      = INIT;
      init_idx_d   = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      have_last_d  = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      drop_pulse_d = 1'b0;
      wr_en_d      = 1'b0;
      shadow_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      init_idx_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      have_last_q  <= 1'b0;
      last_ts_q    <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      have_last_q  <= have_last_d;
      last_ts_q    <= last_ts_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign in_ready          = ready;
  assign inst_list_wr_en   = wr_en_q;
  assign inst_list_wr_addr = wr_addr_q;
  assign inst_list_wr_data = wr_data_q;
  assign init_done         = (state_q == RUN);
  assign occupancy         = occ_q;
  assign drop_pulse        = drop_pulse_q;
  assign drop_count        = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_inst_scheduler.sv
// ------------------------------------------------------------------
// tb_pulse_inst_scheduler: directed scenarios plus random traffic vs a queue model
// rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_inst_scheduler;

  localparam int          NE        = 32;
  localparam logic [25:0] PARK_WORD = 26'h3FFFFFC;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [23:0] glb_counter, in_timestamp;
  logic [1:0]  in_direction;
  logic        in_ready, inst_list_wr_en, init_done, drop_pulse;
  logic [4:0]  inst_list_wr_addr;
  logic [25:0] inst_list_wr_data;
  logic [5:0]  occupancy;
  logic [7:0]  drop_count;

  pulse_inst_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .glb_counter       (glb_counter),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_timestamp      (in_timestamp),
    .in_direction      (in_direction),
    .inst_list_wr_en   (inst_list_wr_en),
    .inst_list_wr_addr (inst_list_wr_addr),
    .inst_list_wr_data (inst_list_wr_data),
    .init_done         (init_done),
    .occupancy         (occupancy),
    .drop_pulse        (drop_pulse),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: outstanding entries are simply a queue of timestamps.
  bit          running;
  int unsigned pend[$];
  int          wr_ptr_m;
  bit          have_last_m;
  int unsigned last_ts_m;
  int          drop_cnt_m;
  int unsigned g;
  bit          exp_wr_en, exp_drop;
  int          exp_addr;
  logic [25:0] exp_data;

  task automatic model_clear();
    running     = 1'b0;
    pend.delete();
    wr_ptr_m    = 0;
    have_last_m = 1'b0;
  endtask

  task automatic tick(input bit v, input int unsigned ts, input int unsigned dir);
    bit ready, ret;
    in_valid     = v;
    in_timestamp = ts[23:0];
    in_direction = dir[1:0];
    glb_counter  = g[23:0];
    exp_wr_en    = 1'b0;
    exp_drop     = 1'b0;
    if (running) begin
      ready = (pend.size() != NE);
      ret   = (pend.size() != 0) && (pend[0] == g);
      if (v && ready) begin
        if ((ts < g + 3) || (have_last_m && ts <= last_ts_m)) begin
          exp_drop = 1'b1;
          if (drop_cnt_m < 255) drop_cnt_m++;
        end else begin
          exp_wr_en   = 1'b1;
          exp_addr    = wr_ptr_m;
          exp_data    = {ts[23:0], dir[1:0]};
          wr_ptr_m    = (wr_ptr_m + 1) % NE;
          last_ts_m   = ts;
          have_last_m = 1'b1;
          pend.push_back(ts);
        end
      end
      if (ret) void'(pend.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_init_sequence(input string tag);
    logic [4:0] a;
    in_valid = 1'b0;
    for (int i = 0; i < NE; i++) begin
      @(posedge clk);
      #1;
      a = i[4:0];
      tests++;
      if ({inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, init_done} !==
          {1'b1, a, PARK_WORD, 1'b0}) begin
        fails++;
        $display("FAIL %s slot %0d: got en=%b addr=%0d data=%h done=%b, expected en=1 addr=%0d data=%h done=0",
                 tag, i, inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, init_done, a, PARK_WORD);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if ({init_done, in_ready, occupancy, inst_list_wr_en} !== {1'b1, 1'b1, 6'd0, 1'b0}) begin
      fails++;
      $display("FAIL %s end: got done=%b ready=%b occ=%0d en=%b, expected done=1 ready=1 occ=0 en=0",
               tag, init_done, in_ready, occupancy, inst_list_wr_en);
    end
    running = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; g = 0;
    glb_counter = '0; in_timestamp = '0; in_direction = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, init_done, occupancy,
         drop_pulse, drop_count} !== '0) begin
      fails++;
      $display("FAIL reset_values: got ready=%b en=%b addr=%0d data=%h done=%b occ=%0d drop=%b cnt=%0d, expected all 0",
               in_ready, inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, init_done, occupancy,
               drop_pulse, drop_count);
    end
    drop_cnt_m = 0;
    model_clear();
    rst = 1'b0;
    test_init_sequence("init_after_reset");
  endtask

  task automatic test_accept_retire();
    g = 100;
    tick(1'b1, 110, 2);
    tests++;
    if ({inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, occupancy} !==
        {1'b1, 5'd0, 24'd110, 2'd2, 6'd1}) begin
      fails++;
      $display("FAIL accept_write: got en=%b addr=%0d data=%h occ=%0d, expected en=1 addr=0 data=%h occ=1",
               inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, occupancy, {24'd110, 2'd2});
    end
    for (int t = 101; t <= 110; t++) begin
      g = t;
      tick(1'b0, 0, 0);
      tests++;
      if (occupancy !== 6'(pend.size())) begin
        fails++;
        $display("FAIL retire_occ g=%0d: got %0d expected %0d", t, occupancy, pend.size());
      end
    end
    tests++;
    if (occupancy !== 6'd0) begin
      fails++;
      $display("FAIL retire_final: got occ=%0d expected 0", occupancy);
    end
  endtask

  task automatic test_drops();
    g = 100;
    tick(1'b1, 102, 0);
    tests++;
    if ({drop_pulse, drop_count, inst_list_wr_en} !== {1'b1, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL late_drop: got drop=%b cnt=%0d en=%b, expected drop=1 cnt=1 en=0",
               drop_pulse, drop_count, inst_list_wr_en);
    end
    tick(1'b1, 200, 1);
    tests++;
    if ({drop_pulse, inst_list_wr_en, inst_list_wr_addr} !== {1'b0, 1'b1, 5'd1}) begin
      fails++;
      $display("FAIL accept_200: got drop=%b en=%b addr=%0d, expected drop=0 en=1 addr=1",
               drop_pulse, inst_list_wr_en, inst_list_wr_addr);
    end
    tick(1'b1, 150, 3);
    tests++;
    if ({drop_pulse, drop_count, inst_list_wr_en, occupancy} !== {1'b1, 8'd2, 1'b0, 6'd1}) begin
      fails++;
      $display("FAIL order_drop: got drop=%b cnt=%0d en=%b occ=%0d, expected drop=1 cnt=2 en=0 occ=1",
               drop_pulse, drop_count, inst_list_wr_en, occupancy);
    end
    tick(1'b0, 0, 0);
    tests++;
    if (drop_pulse !== 1'b0) begin
      fails++;
      $display("FAIL drop_width: got drop=%b expected 0", drop_pulse);
    end
  endtask

  task automatic test_full();
    g = 100;
    for (int k = 0; k < 31; k++) begin
      tick(1'b1, 201 + k, k % 4);
      tests++;
      if ({inst_list_wr_en, inst_list_wr_addr} !== {1'b1, 5'(exp_addr)}) begin
        fails++;
        $display("FAIL fill_%0d: got en=%b addr=%0d, expected en=1 addr=%0d",
                 k, inst_list_wr_en, inst_list_wr_addr, exp_addr);
      end
    end
    tests++;
    if ({occupancy, in_ready} !== {6'd32, 1'b0}) begin
      fails++;
      $display("FAIL full_state: got occ=%0d ready=%b expected occ=32 ready=0", occupancy, in_ready);
    end
    g = 200;
    tick(1'b1, 300, 0);
    tests++;
    if ({inst_list_wr_en, occupancy, in_ready} !== {1'b0, 6'd31, 1'b1}) begin
      fails++;
      $display("FAIL full_retire: got en=%b occ=%0d ready=%b, expected en=0 occ=31 ready=1",
               inst_list_wr_en, occupancy, in_ready);
    end
    g = 150;
    tick(1'b1, 300, 1);
    tests++;
    if ({inst_list_wr_en, inst_list_wr_addr, occupancy} !== {1'b1, 5'd1, 6'd32}) begin
      fails++;
      $display("FAIL wrap_write: got en=%b addr=%0d occ=%0d, expected en=1 addr=1 occ=32",
               inst_list_wr_en, inst_list_wr_addr, occupancy);
    end
  endtask

  task automatic test_simultaneous();
    while (pend.size() > 5) begin
      g = pend[0];
      tick(1'b0, 0, 0);
      tests++;
      if (occupancy !== 6'(pend.size())) begin
        fails++;
        $display("FAIL drain_occ: got %0d expected %0d", occupancy, pend.size());
      end
    end
    g = pend[0];
    tick(1'b1, last_ts_m + 10, 2);
    tests++;
    if ({occupancy, inst_list_wr_en, inst_list_wr_addr} !== {6'd5, 1'b1, 5'(exp_addr)}) begin
      fails++;
      $display("FAIL simul_accept_retire: got occ=%0d en=%b addr=%0d, expected occ=5 en=1 addr=%0d",
               occupancy, inst_list_wr_en, inst_list_wr_addr, exp_addr);
    end
    g = pend[0];
    tick(1'b0, 0, 0);
    tests++;
    if (occupancy !== 6'd4) begin
      fails++;
      $display("FAIL rd_ptr_advance: got occ=%0d expected 4", occupancy);
    end
  endtask

  task automatic test_flush();
    g = pend[0] - 1;
    while (pend.size() < 7) tick(1'b1, last_ts_m + 5, 1);
    tests++;
    if (occupancy !== 6'd7) begin
      fails++;
      $display("FAIL pre_flush_occ: got %0d expected 7", occupancy);
    end
    flush        = 1'b1;
    in_valid     = 1'b1;
    in_timestamp = 24'(last_ts_m + 50);
    @(posedge clk);
    #1;
    flush = 1'b0;
    tests++;
    if ({inst_list_wr_en, drop_count, init_done} !== {1'b0, 8'd2, 1'b0}) begin
      fails++;
      $display("FAIL flush_abandon: got en=%b cnt=%0d done=%b, expected en=0 cnt=2 done=0",
               inst_list_wr_en, drop_count, init_done);
    end
    model_clear();
    test_init_sequence("init_after_flush");
    g = 1000;
    tick(1'b1, 1010, 3);
    tests++;
    if ({inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, drop_count, occupancy} !==
        {1'b1, 5'd0, 24'd1010, 2'd3, 8'd2, 6'd1}) begin
      fails++;
      $display("FAIL post_flush_write: got en=%b addr=%0d data=%h cnt=%0d occ=%0d, expected en=1 addr=0 data=%h cnt=2 occ=1",
               inst_list_wr_en, inst_list_wr_addr, inst_list_wr_data, drop_count, occupancy,
               {24'd1010, 2'd3});
    end
  endtask

  task automatic test_random();
    int unsigned ts, base;
    bit v;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 1) g++;
      v = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 9))
        0: ts = g + $urandom_range(0, 3);
        1: ts = have_last_m ? last_ts_m - $urandom_range(0, 2) : g + 5;
        default: begin
          base = (last_ts_m + 1 > g + 3) ? last_ts_m + 1 : g + 3;
          ts   = base + $urandom_range(0, 4);
        end
      endcase
      tick(v, ts, $urandom_range(0, 3));
      tests++;
      if ({inst_list_wr_en, drop_pulse, drop_count, occupancy, in_ready} !==
          {exp_wr_en, exp_drop, 8'(drop_cnt_m), 6'(pend.size()), pend.size() != NE}) begin
        fails++;
        $display("FAIL rand_%0d: got en=%b drop=%b cnt=%0d occ=%0d ready=%b, expected en=%b drop=%b cnt=%0d occ=%0d ready=%b",
                 n, inst_list_wr_en, drop_pulse, drop_count, occupancy, in_ready,
                 exp_wr_en, exp_drop, drop_cnt_m, pend.size(), pend.size() != NE);
      end
      if (exp_wr_en) begin
        tests++;
        if ({inst_list_wr_addr, inst_list_wr_data} !== {5'(exp_addr), exp_data}) begin
          fails++;
          $display("FAIL rand_write_%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                   n, inst_list_wr_addr, inst_list_wr_data, exp_addr, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept_retire();
    test_drops();
    test_full();
    test_simultaneous();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
